// File: rtl/alu_core.sv
// alu_core: RV32IM integer ALU for the EX stage. Registered result, 1-cycle latency,
// one operation per cycle. Define ALU_DIV_EN to build DIV/DIVU/REM/REMU; without it
// those codes return 0 and no divider logic exists.
module alu_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,        // asynchronous, active-low
   input  logic            in_valid,
   input  logic [XLEN-1:0] opa,
   input  logic [XLEN-1:0] opb,
   input  logic [4:0]      func,
   output logic [XLEN-1:0] result,
   output logic            out_valid
);

   typedef enum logic [4:0] {
      OP_ADD    = 5'h00,
      OP_SUB    = 5'h01,
      OP_SLT    = 5'h02,
      OP_SLTU   = 5'h03,
      OP_AND    = 5'h04,
      OP_OR     = 5'h05,
      OP_XOR    = 5'h06,
      OP_SLL    = 5'h07,
      OP_SRL    = 5'h08,
      OP_SRA    = 5'h09,
      OP_MUL    = 5'h0A,
      OP_MULH   = 5'h0B,
      OP_MULHSU = 5'h0C,
      OP_MULHU  = 5'h0D,
      OP_DIV    = 5'h0E,
      OP_DIVU   = 5'h0F,
      OP_REM    = 5'h10,
      OP_REMU   = 5'h11
   } alu_op_e;

   logic [4:0]        shamt;
   logic              mul_a_signed;
   logic              mul_b_signed;
   logic signed [63:0] mul_a;
   logic signed [63:0] mul_b;
   logic [63:0]       prod;
   logic [XLEN-1:0]   alu_out;

   assign shamt = opb[4:0];

   // One shared multiplier: operands are sign- or zero-extended per code so a single
   // signed product covers MUL/MULH/MULHSU/MULHU (low 64 bits are exact modulo 2^64).
   always_comb begin
      mul_a_signed = (func == OP_MULH) || (func == OP_MULHSU);
      mul_b_signed = (func == OP_MULH);
      mul_a = {{32{mul_a_signed & opa[31]}}, opa};
      mul_b = {{32{mul_b_signed & opb[31]}}, opb};
      prod  = mul_a * mul_b;
   end

`ifdef ALU_DIV_EN
   logic [XLEN-1:0] div_q;
   logic [XLEN-1:0] div_r;
   logic [XLEN-1:0] divu_q;
   logic [XLEN-1:0] divu_r;
   logic            div_ovf;

   // Single-cycle divide with the RV32M special cases resolved before the divider.
   always_comb begin
      div_ovf = (opa == 32'h8000_0000) && (opb == 32'hFFFF_FFFF);
      div_q   = '1;
      div_r   = opa;
      divu_q  = '1;
      divu_r  = opa;
      if (opb != '0) begin
         divu_q = opa / opb;
         divu_r = opa % opb;
         if (div_ovf) begin
            div_q = 32'h8000_0000;
            div_r = '0;
         end else begin
            div_q = $signed(opa) / $signed(opb);
            div_r = $signed(opa) % $signed(opb);
         end
      end
   end
`endif

   // Next-result selection by function code.
   always_comb begin
      // NOTE: default first so every path assigns alu_out and no latch is inferred.
      alu_out = '0;
      case (func)
         OP_ADD:    alu_out = opa + opb;
         OP_SUB:    alu_out = opa - opb;
         OP_SLT:    alu_out = {31'b0, $signed(opa) < $signed(opb)};
         OP_SLTU:   alu_out = {31'b0, opa < opb};
         OP_AND:    alu_out = opa & opb;
         OP_OR:     alu_out = opa | opb;
         OP_XOR:    alu_out = opa ^ opb;
         OP_SLL:    alu_out = opa << shamt;
         OP_SRL:    alu_out = opa >> shamt;
         OP_SRA:    alu_out = $signed(opa) >>> shamt;
         OP_MUL:    alu_out = prod[31:0];
         OP_MULH,
         OP_MULHSU,
         OP_MULHU:  alu_out = prod[63:32];
`ifdef ALU_DIV_EN
         OP_DIV:    alu_out = div_q;
         OP_DIVU:   alu_out = divu_q;
         OP_REM:    alu_out = div_r;
         OP_REMU:   alu_out = divu_r;
`endif
         default:   alu_out = '0;
      endcase
   end

   // Output register: valid always follows in_valid, result only loads on valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result    <= '0;
         out_valid <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so all flops update from pre-edge values.
         out_valid <= in_valid;
         if (in_valid) result <= alu_out;
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: randomized + directed stimulus, scoreboard queue filled from a
// behavioural model at each clock edge, monitor pops and compares on the falling edge.
module tb_alu_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] opa = '0;
   logic [31:0] opb = '0;
   logic [4:0]  func = '0;
   logic [31:0] result;
   logic        out_valid;

   typedef struct {
      logic        v;
      logic [31:0] r;
      logic [4:0]  f;
   } exp_t;

   exp_t        sb_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] model_last  = '0;

   alu_core #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .opa       (opa),
      .opb       (opb),
      .func      (func),
      .result    (result),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference ALU computed from the instruction definitions with 64-bit arithmetic.
   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] f);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'b0, a});
      longint ub = longint'({32'b0, b});
      longint p;
      case (f)
         5'h00: return a + b;
         5'h01: return a - b;
         5'h02: return (sa < sb) ? 32'd1 : 32'd0;
         5'h03: return (ua < ub) ? 32'd1 : 32'd0;
         5'h04: return a & b;
         5'h05: return a | b;
         5'h06: return a ^ b;
         5'h07: return a << b[4:0];
         5'h08: return a >> b[4:0];
         5'h09: begin p = sa >>> b[4:0]; return p[31:0]; end
         5'h0A: begin p = sa * sb; return p[31:0]; end
         5'h0B: begin p = sa * sb; return p[63:32]; end
         5'h0C: begin p = sa * ub; return p[63:32]; end
         5'h0D: begin p = ua * ub; return p[63:32]; end
`ifdef ALU_DIV_EN
         5'h0E: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         5'h0F: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         5'h10: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         5'h11: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
`endif
         default: return 32'h0;
      endcase
   endfunction

   // Model: each edge out of reset yields one expected output (valid + held result).
   always @(posedge clk) begin
      exp_t e;
      if (!rst) begin
         model_last = '0;
      end else begin
         if (in_valid) model_last = ref_alu(opa, opb, func);
         e.v = in_valid;
         e.r = model_last;
         e.f = func;
         sb_q.push_back(e);
      end
   end

   // Monitor: compare DUT outputs against the oldest expectation away from the edge.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check($sformatf("out_valid f=%0h", e.f), {31'b0, out_valid}, {31'b0, e.v});
         check($sformatf("result f=%0h", e.f), result, e.r);
      end
   end

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] f);
      @(negedge clk);
      in_valid = v;
      opa      = a;
      opb      = b;
      func     = f;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return $urandom_range(0, 9);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held with live inputs: outputs must stay cleared.
      #1 rst = 1'b0;
      in_valid = 1'b1;
      opa = $urandom;
      opb = $urandom;
      func = 5'h00;
      repeat (3) @(negedge clk);
      check("reset result", result, 32'h0);
      check("reset out_valid", {31'b0, out_valid}, 32'h0);

      // Release together with the first operation: 5 + 7.
      @(negedge clk);
      rst = 1'b1;
      opa = 32'd5; opb = 32'd7; func = 5'h00; in_valid = 1'b1;

      // Multiply checks.
      drive(1, 32'h3B9ACA00, 32'h3B9ACA00, 5'h0A);
      drive(1, 32'h3B9ACA00, 32'h3B9ACA00, 5'h0D);
      drive(1, 32'h3B9ACA00, 32'h3B9ACA00, 5'h0B);
      // Signed multiply / compare.
      drive(1, 32'hFFFFFFFF, 32'd2, 5'h0B);
      drive(1, 32'hFFFFFFFF, 32'd2, 5'h0D);
      drive(1, 32'hFFFFFFFF, 32'd2, 5'h0C);
      drive(1, 32'hFFFFFFFF, 32'd2, 5'h02);
      drive(1, 32'hFFFFFFFF, 32'd2, 5'h03);
      // Shifts: upper bits of opb ignored.
      drive(1, 32'h80000000, 32'h24, 5'h09);
      drive(1, 32'h80000000, 32'h24, 5'h08);
      drive(1, 32'h80000000, 32'h24, 5'h07);
      // Back-to-back, then hold with changing inputs.
      drive(1, 32'd10, 32'd3, 5'h00);
      drive(1, 32'd10, 32'd3, 5'h01);
      drive(0, 32'd99, 32'd1, 5'h05);
      drive(0, 32'd42, 32'd8, 5'h0A);
      // Divide codes (zero when the divider is not built).
      drive(1, 32'hFFFFFFF9, 32'd2, 5'h0E);
      drive(1, 32'hFFFFFFF9, 32'd2, 5'h10);
      drive(1, 32'd123, 32'd0, 5'h0F);
      drive(1, 32'd9, 32'd0, 5'h11);
      drive(1, 32'h80000000, 32'hFFFFFFFF, 5'h0E);
      drive(1, 32'h80000000, 32'hFFFFFFFF, 5'h10);
      drive(1, 32'd100, 32'd0, 5'h0E);
      drive(1, 32'd100, 32'd0, 5'h10);
      // Unused codes.
      drive(1, 32'h12345678, 32'h9ABCDEF0, 5'h12);
      drive(1, 32'h12345678, 32'h9ABCDEF0, 5'h1F);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 3) != 0), pick_operand(), pick_operand(),
               5'($urandom_range(0, 31)));
      end

      // Asynchronous reset mid-run, asserted away from any clock edge.
      drive(0, '0, '0, 5'h00);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async reset result", result, 32'h0);
      check("async reset out_valid", {31'b0, out_valid}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      drive(0, 32'd1, 32'd1, 5'h00);
      drive(1, 32'd1, 32'd1, 5'h00);
      for (int i = 0; i < 100; i++) begin
         drive(($urandom_range(0, 3) != 0), pick_operand(), pick_operand(),
               5'($urandom_range(0, 17)));
      end

      drive(0, '0, '0, 5'h00);
      repeat (3) @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
